// File: rtl/hex_display_feeder.sv
// Converts a binary value into per-digit hex-driver nibbles and dash flags, in raw hex
// or decimal (iterative double-dabble, one bit per cycle), over a valid/ready handshake.
module hex_display_feeder #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned DATA_W     = 20
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [DATA_W-1:0]       value_in,
    input  logic                    value_valid,
    output logic                    value_ready,
    input  logic                    mode_hex,
    input  logic                    is_signed,
    output logic [4*NUM_DIGITS-1:0] digit_nib,
    output logic [NUM_DIGITS-1:0]   digit_dash,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    // Decimal digit count of 2^DATA_W-1 is floor(DATA_W*log10(2))+1.
    localparam int unsigned BCD_DIGITS = (DATA_W * 30103) / 100000 + 1;
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
    localparam int unsigned NIB_W      = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W      = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {StIdle, StConvert, StCommit} state_e;

    state_e                state_q, state_d;
    logic [DATA_W-1:0]     val_q, val_d;
    logic                  hex_q, hex_d;
    logic                  neg_q, neg_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NIB_W-1:0]      nib_q, new_nib;
    logic [NUM_DIGITS-1:0] dash_q, new_dash;
    logic                  ovf_q, new_ovf;
    logic                  accept, in_neg;
    logic                  unused_bcd_msb;

    logic [DATA_W+NIB_W-1:0] val_ext;
    logic [BCD_W+NIB_W-1:0]  bcd_ext;

    assign value_ready = (state_q == StIdle);
    assign busy        = (state_q == StConvert);
    assign done        = (state_q == StCommit);
    assign accept      = value_valid && value_ready;
    assign in_neg      = !mode_hex && is_signed && value_in[DATA_W-1];

    // Double-dabble correction step applied before each shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Magnitude is below 2^DATA_W, so the top BCD bit never carries out.
    assign unused_bcd_msb = bcd_adj[BCD_W-1];

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        hex_d   = hex_q;
        neg_d   = neg_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    hex_d   = mode_hex;
                    neg_d   = in_neg;
                    val_d   = in_neg ? (~value_in + DATA_W'(1)) : value_in;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = mode_hex ? StCommit : StConvert;
                end
            end
            StConvert: begin
                bcd_d = {bcd_adj[BCD_W-2:0], val_q[DATA_W-1]};
                val_d = val_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = StCommit;
                end
            end
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Display contents derived from the latched value (hex) or finished BCD (decimal).
    always_comb begin
        val_ext  = (DATA_W + NIB_W)'(val_q);
        bcd_ext  = (BCD_W + NIB_W)'(bcd_q);
        new_nib  = '0;
        new_dash = '0;
        new_ovf  = 1'b0;
        if (hex_q) begin
            new_nib = val_ext[NIB_W-1:0];
            new_ovf = |(val_ext >> NIB_W);
        end else if (neg_q) begin
            new_nib                 = {4'd0, bcd_ext[NIB_W-5:0]};
            new_dash[NUM_DIGITS-1]  = 1'b1;
            new_ovf                 = |(bcd_ext >> (NIB_W - 4));
        end else begin
            new_nib = bcd_ext[NIB_W-1:0];
            new_ovf = |(bcd_ext >> NIB_W);
        end
        if (new_ovf) begin
            new_nib  = '0;
            new_dash = '1;
        end
    end

    // New contents appear together with done and are held from the end of COMMIT.
    assign digit_nib  = done ? new_nib  : nib_q;
    assign digit_dash = done ? new_dash : dash_q;
    assign overflow   = done ? new_ovf  : ovf_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            val_q   <= '0;
            hex_q   <= 1'b0;
            neg_q   <= 1'b0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            nib_q   <= '0;
            dash_q  <= '1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            hex_q   <= hex_d;
            neg_q   <= neg_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            if (state_q == StCommit) begin
                nib_q  <= new_nib;
                dash_q <= new_dash;
                ovf_q  <= new_ovf;
            end
        end
    end

endmodule

// File: tb/tb_hex_display_feeder.sv
// Randomized bench for hex_display_feeder: arithmetic reference model checked every cycle,
// plus literal expectations for the directed cases.
module tb_hex_display_feeder;
    localparam int ND = 6;
    localparam int DW = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] value_in = '0;
    logic          value_valid = 1'b0;
    logic          value_ready;
    logic          mode_hex = 1'b0;
    logic          is_signed = 1'b0;
    logic [4*ND-1:0] digit_nib;
    logic [ND-1:0] digit_dash;
    logic          busy, done, overflow;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit chk_en = 0;

    hex_display_feeder #(.NUM_DIGITS(ND), .DATA_W(DW)) dut (
        .Clk(clk), .Reset(rst), .value_in(value_in), .value_valid(value_valid),
        .value_ready(value_ready), .mode_hex(mode_hex), .is_signed(is_signed),
        .digit_nib(digit_nib), .digit_dash(digit_dash), .busy(busy), .done(done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // Expected display from the value using plain integer arithmetic.
    function automatic void ref_disp(input logic [DW-1:0] v, input logic hx, input logic sg,
                                     output logic [4*ND-1:0] nib, output logic [ND-1:0] dash,
                                     output logic ovf);
        longint mag, p;
        logic neg;
        nib = '0;
        dash = '0;
        if (hx) begin
            nib = (4*ND)'(longint'(v));
            ovf = longint'(v) >= (longint'(1) << (4*ND));
        end else begin
            neg = sg && v[DW-1];
            mag = neg ? (longint'(1) << DW) - longint'(v) : longint'(v);
            p = 1;
            for (int k = 0; k < ND; k++) begin
                nib[4*k +: 4] = 4'((mag / p) % 10);
                p = p * 10;
            end
            ovf = neg ? (mag >= p / 10) : (mag >= p);
            if (neg) begin
                nib[4*(ND-1) +: 4] = 4'd0;
                dash[ND-1] = 1'b1;
            end
        end
        if (ovf) begin
            nib = '0;
            dash = '1;
        end
    endfunction

    // Cycle-level model: conversion countdown, pending commit, held display.
    int              m_conv = 0;
    bit              m_commit = 0;
    logic [4*ND-1:0] m_nib = '0, m_rnib = '0;
    logic [ND-1:0]   m_dash = '1, m_rdash = '0;
    logic            m_ovf = 1'b0, m_rovf = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_conv = 0; m_commit = 0; m_nib = '0; m_dash = '1; m_ovf = 1'b0;
        end else if (m_commit) begin
            m_commit = 0; m_nib = m_rnib; m_dash = m_rdash; m_ovf = m_rovf;
        end else if (m_conv > 0) begin
            m_conv--;
            if (m_conv == 0) m_commit = 1;
        end else if (value_valid) begin
            ref_disp(value_in, mode_hex, is_signed, m_rnib, m_rdash, m_rovf);
            if (mode_hex) m_commit = 1;
            else m_conv = DW;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [4*ND-1:0] en;
            logic [ND-1:0]   ed;
            logic            eo;
            en = m_commit ? m_rnib  : m_nib;
            ed = m_commit ? m_rdash : m_dash;
            eo = m_commit ? m_rovf  : m_ovf;
            check("model_cycle",
                  {28'd0, value_ready, busy, done, overflow, digit_dash, digit_nib},
                  {28'd0, (!m_commit && m_conv == 0), (m_conv > 0), m_commit, eo, ed, en});
        end
    end

    // Present a value, wait for accept and for done. Returns to caller on the done negedge.
    task automatic send(input logic [DW-1:0] v, input logic hx, input logic sg,
                        output int wt, output int lat, output int busy_n);
        value_in = v; mode_hex = hx; is_signed = sg; value_valid = 1'b1;
        wt = 0;
        while (!value_ready && wt < 100) begin
            @(negedge clk);
            wt++;
        end
        @(posedge clk);
        @(negedge clk);
        value_valid = 1'b0;
        lat = 1;
        busy_n = busy ? 1 : 0;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
            if (busy) busy_n++;
        end
    endtask

    int wt, lat, bn, done_seen;
    logic [DW-1:0] rv;
    logic rh, rs;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1;
        done_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("reset_dash", 64'(digit_dash), 64'(6'b111111));
        check("reset_nib", 64'(digit_nib), 64'd0);
        check("reset_ready_busy", {62'd0, value_ready, busy}, {62'd0, 1'b1, 1'b0});
        check("reset_no_done", 64'(done_seen), 64'd0);

        send(20'd123456, 1'b0, 1'b0, wt, lat, bn);
        check("dec_latency", 64'(lat), 64'd21);
        check("dec_busy_cycles", 64'(bn), 64'd20);
        check("dec_123456", {39'd0, overflow, digit_dash, digit_nib}, {39'd0, 1'b0, 6'd0, 24'h123456});

        send(20'hABCDE, 1'b1, 1'b0, wt, lat, bn);
        check("hex_latency", 64'(lat), 64'd1);
        check("hex_abcde", {40'd0, digit_dash, digit_nib}, {40'd0, 6'd0, 24'h0ABCDE});
        send(20'h00007, 1'b1, 1'b1, wt, lat, bn);
        check("b2b_wait", 64'(wt), 64'd1);
        check("hex_7", 64'(digit_nib), 64'h000007);

        send(20'hFFFD6, 1'b0, 1'b1, wt, lat, bn);
        check("neg42", {39'd0, overflow, digit_dash, digit_nib}, {39'd0, 1'b0, 6'b100000, 24'h000042});
        send(20'h80000, 1'b0, 1'b1, wt, lat, bn);
        check("most_neg_ovf", {39'd0, overflow, digit_dash, digit_nib}, {39'd0, 1'b1, 6'b111111, 24'h0});
        send(20'd999999, 1'b0, 1'b0, wt, lat, bn);
        check("dec_999999", {39'd0, overflow, digit_dash, digit_nib}, {39'd0, 1'b0, 6'd0, 24'h999999});
        send(20'd1000000, 1'b0, 1'b0, wt, lat, bn);
        check("dec_1e6_ovf", {39'd0, overflow, digit_dash, digit_nib}, {39'd0, 1'b1, 6'b111111, 24'h0});
        @(negedge clk);
        check("ovf_held", 64'(overflow), 64'd1);
        send(20'd0, 1'b0, 1'b1, wt, lat, bn);
        check("signed_zero", {39'd0, overflow, digit_dash, digit_nib}, {39'd0, 1'b0, 6'd0, 24'h0});

        // Reset in the middle of a decimal conversion with valid toggling while busy.
        value_in = 20'd555; mode_hex = 1'b0; is_signed = 1'b0; value_valid = 1'b1;
        wt = 0;
        while (!value_ready && wt < 100) begin
            @(negedge clk);
            wt++;
        end
        @(posedge clk);
        done_seen = 0;
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            if (done) done_seen++;
            value_valid = ~value_valid;
            value_in = DW'($urandom);
        end
        @(negedge clk);
        rst = 1'b1;
        value_in = 20'd321; value_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_display", {40'd0, digit_dash, digit_nib}, {40'd0, 6'b111111, 24'h0});
        check("abort_state", {61'd0, value_ready, busy, done}, {61'd0, 1'b1, 1'b0, 1'b0});
        check("abort_no_done", 64'(done_seen), 64'd0);
        send(20'd321, 1'b0, 1'b0, wt, lat, bn);
        check("held_valid_wait", 64'(wt), 64'd0);
        check("held_valid_commit", 64'(digit_nib), 64'h000321);

        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            rh = 1'($urandom_range(0, 2) == 0);
            rs = 1'($urandom);
            case ($urandom_range(0, 3))
                0: rv = DW'($urandom_range(0, 99));
                1: rv = DW'($urandom_range(999990, 1048575));
                2: rv = DW'($urandom_range(0, 15)) | 20'h80000;
                default: rv = DW'($urandom);
            endcase
            send(rv, rh, rs, wt, lat, bn);
            check("rand_latency", 64'(lat), rh ? 64'd1 : 64'd21);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/hex_display_feeder.md
Name: hex_display_feeder

Overview:
Sequential front end for the per-digit 7-segment hex drivers. Accepts a binary result value over a valid/ready handshake. Converts it to NUM_DIGITS display nibbles, either raw hex or decimal via iterative double-dabble, and generates the per-digit dash flags. Each nibble/dash pair feeds one hex driver instance (4-bit digit in, dash in) on the board display, for example the predicted digit, score or cycle counts from the MNIST datapath.

Parameters:
NUM_DIGITS, 6, number of display digits driven (digit NUM_DIGITS-1 is leftmost).
DATA_W, 20, width of value_in in bits.

Ports:
Clk  in  1  system clock; all state on rising edge.
Reset  in  1  synchronous, active-high reset.
value_in  in  DATA_W  value to display; sampled on accept.
value_valid  in  1  upstream has a value; held until accepted.
value_ready  out  1  block can accept a value this cycle.
mode_hex  in  1  sampled on accept. 1 = raw hex nibbles; 0 = decimal.
is_signed  in  1  sampled on accept; decimal mode only. 1 = value_in is two's complement.
digit_nib  out  4*NUM_DIGITS  nibble per digit; digit k at [4k+3:4k].
digit_dash  out  NUM_DIGITS  1 = digit k shows '-'.
busy  out  1  conversion in progress.
done  out  1  one-cycle pulse when new display contents are committed.
overflow  out  1  last committed value did not fit; held until next commit.

Behaviour:
- Reset (any state, including mid-conversion):
  - state=IDLE.
  - digit_nib=0, digit_dash=all ones (display "------").
  - value_ready=1, busy=0, done=0, overflow=0.
  - No done pulse for an aborted conversion.
- States:
  - IDLE: value_ready=1. Accept when value_valid && value_ready: latch value, mode_hex, is_signed.
    - Hex mode goes to COMMIT.
    - Decimal mode goes to CONVERT.
  - CONVERT: value_ready=0, busy=1. Exactly DATA_W cycles; then COMMIT.
  - COMMIT: one cycle. Registers display outputs, pulses done=1, returns to IDLE.
    - value_ready=0 in COMMIT; busy=0 in COMMIT.
- Latency, accept edge to done high:
  - hex mode 1 cycle;
  - decimal mode DATA_W+1 cycles.
  - Back-to-back accept is possible the cycle after done.
- value_valid while not ready is ignored; upstream must hold it. No internal queue.
- Display outputs change only in COMMIT. The previous contents stay stable during CONVERT.
- Hex mode:
  - digit k = latched value bits [4k+3:4k], zero-extended beyond DATA_W.
  - dash=0 on all digits.
  - overflow=1 if any bit at or above 4*NUM_DIGITS is set; then all digits dash.
  - is_signed is ignored.
- Decimal mode, magnitude:
  - Unsigned, or signed with MSB=0: magnitude = value.
  - Signed with MSB=1: magnitude = two's-complement negation, held as DATA_W-bit unsigned. The most negative value, 2^(DATA_W-1), is representable.
- Decimal conversion:
  - Double-dabble: one bit per CONVERT cycle, MSB first.
  - Per cycle: add 3 to every BCD digit >=5, then shift left one bit, inserting the next magnitude bit.
  - The internal BCD register holds enough digits for 2^DATA_W-1 (7 digits at the default).
- Decimal commit, non-negative:
  - Digits NUM_DIGITS-1..0 = BCD digits, leading zeros shown as '0'.
  - overflow=1 if any BCD digit at or above NUM_DIGITS is nonzero.
- Decimal commit, negative:
  - Leftmost digit dash=1 (minus sign); its nibble is 0.
  - Digits NUM_DIGITS-2..0 = BCD digits.
  - overflow=1 if any BCD digit at or above NUM_DIGITS-1 is nonzero.
- On overflow (any mode): digit_nib=0, digit_dash=all ones, overflow=1.
- Zero in decimal: all digits '0', no dash, including signed zero.

Test Plan:
- Reset, idle 5 cycles -> digit_dash=6'b111111, digit_nib=0, value_ready=1, busy=0, done never high.
- Decimal unsigned 20'd123456 -> done exactly 21 cycles after accept; digit_nib=24'h123456, digit_dash=0, overflow=0; busy high for 20 cycles.
- Hex mode 20'hABCDE -> done 1 cycle after accept; digit_nib=24'h0ABCDE, dash=0; immediate second accept of 20'h00007 commits 24'h000007.
- Decimal signed 20'hFFFD6 (-42) -> digit_dash=6'b100000; digits 4..0 = 0,0,0,4,2.
- Signed 20'h80000 (-524288) -> digits 4..0 = 5,2,4,2,8... The magnitude needs 6 digits, so overflow=1 with all dashes. Then unsigned 20'd999999 commits 24'h999999 with overflow=0; unsigned 20'd1000000 gives overflow=1 with all dashes.
- Assert Reset on cycle 10 of a decimal conversion while value_valid toggles during busy -> next cycle all dashes, idle, no done. No value is accepted while busy; the held valid is accepted only after value_ready returns.
